mult_rr_sched: RTL
==================

// Module: mult_rr_sched
// PURPOSE
//  Round-robin scheduler sharing one sequential shift-add multiplier (start/ready core, 2*W-bit
//  product) between two requesters, e.g. the switch-input path and a self-test/pattern source.
//  Captures operands, launches the core, waits for ready and returns the product with a done pulse.
//  Sits between the requesters and the multiplier; its product feeds binary->BCD and display logic.
// PARAMETERS
//  W        4        operand width; product width is 2*W
//  TIMEOUT  2*W+4    max cycles in WAIT before abort (used only with MULT_SCHED_TIMEOUT_EN)
// PORTS
//  clk       in   1    system clock, all logic on rising edge
//  rst_n     in   1    synchronous active-low reset
//  req       in   2    per-requester level request; operands must be stable while req high
//  a0, b0    in   W    requester 0 operands
//  a1, b1    in   W    requester 1 operands
//  gnt       out  2    one-cycle pulse: operands of that requester captured this cycle
//  done      out  2    one-cycle pulse: prod valid for that requester
//  prod      out  2W   last product, held until next done
//  busy      out  1    high in every state except IDLE
//  err       out  1    one-cycle pulse with done on timeout abort (0 without macro)
//  mul_start out  1    one-cycle start pulse to multiplier core
//  mul_a     out  W    operand A to core, held from start until next start
//  mul_b     out  W    operand B to core, held from start until next start
//  mul_ready in   1    core product valid (level; may still be high from previous op)
//  mul_p     in   2W   core product
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE; gnt, done, err, mul_start = 0; prod, mul_a, mul_b = 0;
//   busy=0; RR pointer last=1 (so requester 0 wins first tie). Reset mid-op aborts silently:
//   no done, no err.
//  FSM: IDLE -> START -> WAIT -> DONE -> IDLE.
//   IDLE : if any req bit set at edge -> START; winner = sole requester, or on tie the one != last.
//   START: gnt[winner]=1, mul_start=1, mul_a/mul_b <= winner operands, last <= winner; -> WAIT.
//   WAIT : mul_ready ignored in first WAIT cycle (stale ready); thereafter mul_ready=1 -> DONE
//          with prod <= mul_p registered on that edge.
//   DONE : done[last]=1 for one cycle; -> IDLE.
//  Latency: START to done = core cycles + 2; back-to-back requests have one IDLE cycle between.
//  req sampled only in IDLE; req held high after done starts a new transaction. With both held
//   high, service alternates 0,1,0,1 (fairness). req dropped during START/WAIT/DONE: op completes.
//  gnt and done never both set; at most one bit of each set per cycle.
//  prod is 2W bits unsigned, no truncation; all-ones operands give (2^W-1)^2.
// CONFIGURATION
//  MULT_SCHED_TIMEOUT_EN defined: cycle counter ($clog2(TIMEOUT+1) bits) cleared in START,
//   increments in WAIT; when it reaches TIMEOUT without ready -> DONE with prod <= 0 and err=1
//   coincident with done. Counter reset to 0.
//  Not defined: no counter, WAIT waits indefinitely, err tied 0.
// STRUCTURE
//  Package mult_sched_pkg: typedef enum logic [1:0] {IDLE, START, WAIT, DONE} sched_state_t;
//   typedef logic req_id_t (requester index); localparam N_REQ = 2.
//  Sub-module rr_arb2: combinational 2-way round-robin picker (req[1:0], last -> valid, winner).
//  Top holds FSM, operand/product registers and optional timeout counter.
// TESTING (bench uses behavioural W-cycle multiplier model, W=4)
//  1 req=01, a0=3, b0=5 -> gnt=01 one cycle, mul_start pulse, done=01 with prod=15, busy low after.
//  2 req=11 held, a0=15,b0=15, a1=2,b1=7 after reset -> grants 0,1,0,1; prods 225,14 alternate.
//  3 stale ready: mul_ready high at START -> no done until model raises ready for new op.
//  4 rst_n=0 during WAIT -> next cycle IDLE, all outputs 0, no done; next req=10 wins immediately.
//  5 MULT_SCHED_TIMEOUT_EN, model never readies -> after TIMEOUT=12 WAIT cycles done+err, prod=0.
//  6 req dropped after gnt -> op completes, done asserted, scheduler returns to IDLE and stays.

Source files
------------

// File: rtl/mult_sched_pkg.sv
// Shared types for the round-robin multiplier scheduler.
package mult_sched_pkg;

  localparam int unsigned N_REQ = 2;

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} sched_state_t;

  // Requester index: 0 or 1.
  typedef logic req_id_t;

  // One-hot request vector for a requester index.
  function automatic logic [N_REQ-1:0] id_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin picker: on a tie the requester that was not served last wins.
module rr_arb2
  import mult_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  req_id_t          last_i,
  output logic             valid_o,
  output req_id_t          winner_o
);

  // Pick the sole requester, or alternate against the last winner on a tie.
  always_comb begin
    valid_o  = |req_i;
    winner_o = last_i;
    case (req_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = ~last_i;
      default: winner_o = last_i;
    endcase
  end

endmodule

// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one start/ready shift-add multiplier between two requesters.
// Optional feature: define MULT_SCHED_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT cycles
// (done with err, product forced to zero).
module mult_rr_sched
  import mult_sched_pkg::*;
#(
  parameter int unsigned W       = 4,
  parameter int unsigned TIMEOUT = 2 * W + 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [W-1:0]     a0,
  input  logic [W-1:0]     b0,
  input  logic [W-1:0]     a1,
  input  logic [W-1:0]     b1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [2*W-1:0]   prod,
  output logic             busy,
  output logic             err,
  output logic             mul_start,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic             mul_ready,
  input  logic [2*W-1:0]   mul_p
);

  sched_state_t   state_q;
  req_id_t        last_q;
  logic           first_q;
  logic [1:0]     gnt_q;
  logic [1:0]     done_q;
  logic           start_q;
  logic [W-1:0]   mul_a_q;
  logic [W-1:0]   mul_b_q;
  logic [2*W-1:0] prod_q;

  logic    arb_valid;
  req_id_t arb_winner;

  rr_arb2 u_arb (
    .req_i    (req),
    .last_i   (last_q),
    .valid_o  (arb_valid),
    .winner_o (arb_winner)
  );

`ifdef MULT_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  // WAIT-cycle counter: cleared in START, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == START) begin
      cnt_q <= '0;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Abort flag: pulses alongside done when WAIT expires without ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == WAIT && !(mul_ready && !first_q) && cnt_q == CntLast) begin
      err_q <= 1'b1;
    end else begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign err = 1'b0;
`endif

  // Scheduler FSM with registered grant/start/done/operand/product outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      first_q <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      prod_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= '0;
          if (arb_valid) begin
            // Operands are captured here so they are on mul_a/mul_b with the start pulse.
            state_q <= START;
            gnt_q   <= id_onehot(arb_winner);
            start_q <= 1'b1;
            last_q  <= arb_winner;
            mul_a_q <= arb_winner ? a1 : a0;
            mul_b_q <= arb_winner ? b1 : b0;
          end
        end
        START: begin
          state_q <= WAIT;
          gnt_q   <= '0;
          start_q <= 1'b0;
          first_q <= 1'b1;
        end
        WAIT: begin
          first_q <= 1'b0;
          // Ready in the first WAIT cycle may be left over from the previous operation.
          if (mul_ready && !first_q) begin
            state_q <= DONE;
            done_q  <= id_onehot(last_q);
            prod_q  <= mul_p;
          end
`ifdef MULT_SCHED_TIMEOUT_EN
          else if (cnt_q == CntLast) begin
            state_q <= DONE;
            done_q  <= id_onehot(last_q);
            prod_q  <= '0;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign prod      = prod_q;
  assign busy      = (state_q != IDLE);
  assign mul_start = start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule
